count_checker: RTL and testbench

Receive-side monitor for the free-running up-counter bus. It samples a WIDTH-bit count each enabled cycle and checks that every value is the previous value plus one, modulo 2^WIDTH. It locks after a run of good increments and reports skips, wraps and counter restarts, keeping a saturating error count. It sits on the far side of the counter's output pads and is used to measure sampling failures caused by clock skew.

---
 rtl/count_check_pkg.sv | 27 ++
 rtl/count_checker_sat_counter.sv | 35 +++
 rtl/count_checker.sv | 163 ++++++++++++++++
 tb/tb_count_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_check_pkg.sv
// Shared types and helpers for the counter-bus checker: FSM state encoding,
// run-counter sizing and the modulo increment used for expected values.
package count_check_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Wide enough for a lock threshold of up to 15 good increments.
  localparam int RUN_W = 4;

  localparam int MAX_W = 64;

  // Increment modulo 2^w; callers truncate the result to their own width.
  function automatic logic [MAX_W-1:0] mod_inc(input logic [MAX_W-1:0] v,
                                               input int unsigned w);
    logic [MAX_W-1:0] sum;
    sum = v + 64'd1;
    if (w >= MAX_W) begin
      return sum;
    end
    return sum & ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with an
// increment leaves the count at one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_checker.sv
// Receive-side monitor for a free-running up-counter bus: locks onto a run of
// good increments and reports skips, wraps and restarts with error capture.
module count_checker
  import count_check_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic                 restart_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     bad_value,
  output logic [WIDTH-1:0]     exp_value
);

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIDTH-1:0] s0_q, s0_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [1:0]       hist_q, hist_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             restart_pulse_q, restart_pulse_d;
  logic [WIDTH-1:0] bad_q, bad_d;
  logic [WIDTH-1:0] exp_q, exp_d;

  logic [WIDTH-1:0] s1_inc;
  logic             good;
  logic             cmp_valid;
  logic             err_inc;
  logic [RUN_W-1:0] run_plus;

  assign s1_inc    = WIDTH'(mod_inc(64'(s1_q), WIDTH));
  assign good      = (s0_q == s1_inc);
  // hist_q counts enabled samples held in s0/s1, saturating at two.
  assign cmp_valid = en && (hist_q == 2'd2);
  assign run_plus  = run_q + RUN_W'(1);

  always_comb begin
    state_d         = state_q;
    run_d           = run_q;
    s0_d            = s0_q;
    s1_d            = s1_q;
    hist_d          = hist_q;
    err_pulse_d     = 1'b0;
    wrap_pulse_d    = 1'b0;
    restart_pulse_d = 1'b0;
    err_inc         = 1'b0;
    bad_d           = bad_q;
    exp_d           = exp_q;

    if (!en) begin
      state_d = ST_EMPTY;
      run_d   = '0;
      hist_d  = 2'd0;
    end else begin
      s0_d = q_in;
      s1_d = s0_q;
      if (hist_q != 2'd2) begin
        hist_d = hist_q + 2'd1;
      end
      case (state_q)
        ST_EMPTY: begin
          state_d = ST_ACQ;
        end
        ST_ACQ: begin
          if (cmp_valid) begin
            if (good) begin
              run_d = run_plus;
              if (run_plus == RUN_W'(LOCK_COUNT)) begin
                state_d = ST_LOCKED;
              end
            end else begin
              run_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (cmp_valid) begin
            if (good) begin
              wrap_pulse_d = &s1_q;
            end else begin
              state_d = ST_ACQ;
              run_d   = '0;
              if (s0_q == '0) begin
                restart_pulse_d = 1'b1;
              end else begin
                err_pulse_d = 1'b1;
                err_inc     = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = ST_EMPTY;
          run_d   = '0;
        end
      endcase
    end

    // A new error overrides a coincident clear of the capture registers.
    if (clear_err) begin
      bad_d = '0;
      exp_d = '0;
    end
    if (err_inc) begin
      bad_d = s0_q;
      exp_d = s1_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_EMPTY;
      run_q           <= '0;
      s0_q            <= '0;
      s1_q            <= '0;
      hist_q          <= 2'd0;
      err_pulse_q     <= 1'b0;
      wrap_pulse_q    <= 1'b0;
      restart_pulse_q <= 1'b0;
      bad_q           <= '0;
      exp_q           <= '0;
    end else begin
      state_q         <= state_d;
      run_q           <= run_d;
      s0_q            <= s0_d;
      s1_q            <= s1_d;
      hist_q          <= hist_d;
      err_pulse_q     <= err_pulse_d;
      wrap_pulse_q    <= wrap_pulse_d;
      restart_pulse_q <= restart_pulse_d;
      bad_q           <= bad_d;
      exp_q           <= exp_d;
    end
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clear_err),
    .cnt   (err_count)
  );

  assign locked        = (state_q == ST_LOCKED);
  assign err_pulse     = err_pulse_q;
  assign wrap_pulse    = wrap_pulse_q;
  assign restart_pulse = restart_pulse_q;
  assign bad_value     = bad_q;
  assign exp_value     = exp_q;

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: directed counter streams push expected
// pulse events; a negedge monitor pops and compares whenever a pulse appears.
module tb_count_checker;

  localparam int WIDTH      = 16;
  localparam int LOCK_COUNT = 4;
  localparam int ERR_CNT_W  = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 en;
  logic [WIDTH-1:0]     q_in;
  logic                 clear_err;
  logic                 locked;
  logic                 err_pulse;
  logic                 wrap_pulse;
  logic                 restart_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic [WIDTH-1:0]     bad_value;
  logic [WIDTH-1:0]     exp_value;

  always #5 clk = ~clk;

  count_checker #(
    .WIDTH      (WIDTH),
    .LOCK_COUNT (LOCK_COUNT),
    .ERR_CNT_W  (ERR_CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .q_in          (q_in),
    .clear_err     (clear_err),
    .locked        (locked),
    .err_pulse     (err_pulse),
    .wrap_pulse    (wrap_pulse),
    .restart_pulse (restart_pulse),
    .err_count     (err_count),
    .bad_value     (bad_value),
    .exp_value     (exp_value)
  );

  // kind is {err, wrap, restart}
  typedef struct {
    logic [2:0]  kind;
    int          cnt;
    logic [15:0] bad;
    logic [15:0] expv;
    logic        lck;
  } ev_t;

  ev_t         sb[$];
  int          total_checks = 0;
  int          pass_checks  = 0;
  int          cur_cnt      = 0;
  logic [15:0] cur_bad      = 16'h0;
  logic [15:0] cur_exp      = 16'h0;
  logic [15:0] v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_checks++;
    if (act === req) begin
      pass_checks++;
    end else begin
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_err(input logic [15:0] bad, input logic [15:0] expv, input int cnt);
    ev_t e;
    cur_cnt = cnt;
    cur_bad = bad;
    cur_exp = expv;
    e.kind = 3'b100; e.cnt = cnt; e.bad = bad; e.expv = expv; e.lck = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_wrap();
    ev_t e;
    e.kind = 3'b010; e.cnt = cur_cnt; e.bad = cur_bad; e.expv = cur_exp; e.lck = 1'b1;
    sb.push_back(e);
  endtask

  task automatic push_restart();
    ev_t e;
    e.kind = 3'b001; e.cnt = cur_cnt; e.bad = cur_bad; e.expv = cur_exp; e.lck = 1'b0;
    sb.push_back(e);
  endtask

  task automatic drv(input logic [15:0] val);
    q_in = val;
    @(negedge clk);
  endtask

  // Drop en for one edge, then stream six consecutive values: locked after the last.
  task automatic relock(input logic [15:0] start);
    en = 1'b0;
    drv(16'h0);
    en = 1'b1;
    for (int i = 0; i < 6; i++) drv(start + 16'(i));
    check("relock", locked, 1);
    v = start + 16'd5;
  endtask

  // Skip one value (v -> v+2), optionally clearing on the edge that registers the error.
  task automatic skip_err(input logic clr, input int cnt);
    push_err(v + 16'd2, v + 16'd1, cnt);
    drv(v + 16'd2);
    clear_err = clr;
    drv(v + 16'd3);
    clear_err = 1'b0;
    drv(v + 16'd4);
    drv(v + 16'd5);
    drv(v + 16'd6);
    v = v + 16'd6;
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (err_pulse || wrap_pulse || restart_pulse) begin
      if (sb.size() == 0) begin
        total_checks++;
        $display("FAIL unexpected_pulse: got err=%0b wrap=%0b restart=%0b, required none",
                 err_pulse, wrap_pulse, restart_pulse);
      end else begin
        e = sb.pop_front();
        $display("event kind=%b err_count=%0d bad=%h exp=%h locked=%0b",
                 {err_pulse, wrap_pulse, restart_pulse}, err_count, bad_value, exp_value, locked);
        check("pulse_kind", {err_pulse, wrap_pulse, restart_pulse}, e.kind);
        check("ev_err_count", err_count, e.cnt);
        check("ev_bad_value", bad_value, e.bad);
        check("ev_exp_value", exp_value, e.expv);
        check("ev_locked", locked, e.lck);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; en = 1'b0; clear_err = 1'b0; q_in = '0; v = '0;
    repeat (2) @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_err_count", err_count, 0);
    check("rst_bad_value", bad_value, 0);
    check("rst_exp_value", exp_value, 0);
    check("rst_pulses", {err_pulse, wrap_pulse, restart_pulse}, 0);

    // Lock
    reset = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) drv(16'(i));
    check("lock_not_yet", locked, 0);
    drv(16'd5);
    check("lock_rise", locked, 1);
    check("lock_err_count", err_count, 0);

    // Wrap
    relock(16'hFFF8);
    drv(16'hFFFE);
    drv(16'hFFFF);
    push_wrap();
    drv(16'h0000);
    drv(16'h0001);
    check("wrap_locked", locked, 1);
    check("wrap_err_count", err_count, 0);

    // Skip
    relock(16'd5);
    drv(16'd11);
    push_err(16'h000D, 16'h000C, 1);
    drv(16'd13);
    drv(16'd14);
    drv(16'd15);
    drv(16'd16);
    drv(16'd17);
    check("skip_relock_early", locked, 0);
    drv(16'd18);
    check("skip_relock", locked, 1);
    check("skip_err_count", err_count, 1);

    // Restart
    relock(16'h011E);
    push_restart();
    drv(16'h0000);
    for (int i = 1; i < 5; i++) drv(16'(i));
    check("restart_relock_early", locked, 0);
    drv(16'd5);
    check("restart_relock", locked, 1);
    check("restart_err_count", err_count, 1);

    // Saturation and clear
    relock(16'h0200);
    for (int i = 0; i < 260; i++) skip_err(1'b0, (cur_cnt < 255) ? cur_cnt + 1 : 255);
    check("sat_err_count", err_count, 255);
    clear_err = 1'b1;
    drv(v + 16'd1);
    clear_err = 1'b0;
    v = v + 16'd1;
    cur_cnt = 0; cur_bad = 16'h0; cur_exp = 16'h0;
    check("clear_err_count", err_count, 0);
    check("clear_bad_value", bad_value, 0);
    check("clear_exp_value", exp_value, 0);
    skip_err(1'b0, 1);
    skip_err(1'b1, 1);
    drv(v + 16'd1);
    v = v + 16'd1;
    check("clr_err_coincident_count", err_count, 1);
    check("pre_reset_locked", locked, 1);

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    check("async_locked", locked, 0);
    check("async_err_count", err_count, 0);
    check("async_bad_value", bad_value, 0);
    check("async_exp_value", exp_value, 0);
    check("async_pulses", {err_pulse, wrap_pulse, restart_pulse}, 0);
    @(negedge clk);
    reset = 1'b1;
    cur_cnt = 0; cur_bad = 16'h0; cur_exp = 16'h0;

    // en low with the counter still running
    relock(16'h0400);
    en = 1'b0;
    drv(16'h0406);
    check("en_low_locked", locked, 0);
    drv(16'h0407);
    drv(16'h0408);
    en = 1'b1;
    for (int i = 0; i < 5; i++) drv(16'h0409 + 16'(i));
    check("en_relock_early", locked, 0);
    drv(16'h040E);
    check("en_relock", locked, 1);
    check("en_err_count", err_count, 0);

    en = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
